// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, data width default and parity-type constants for the UART transmitter
package uart_pkg;

    localparam int DATA_W_DEF = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } state_t;

endpackage

// File: rtl/parity_calc.sv
// parity_calc: parity bit of a data word, even (PAR_TYP=0) or odd (PAR_TYP=1)
module parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] P_DATA,
    input  logic              PAR_TYP,
    output logic              par_bit
);

    // odd parity simply inverts the even-parity reduction
    assign par_bit = (^P_DATA) ^ PAR_TYP;

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: frame sequencer for a UART transmitter driving an external serializer
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] P_DATA,
    input  logic              Data_Valid,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    input  logic              ser_data,
    output logic              ser_en,
    output logic              busy,
    output logic              TX_OUT,
    output logic              frame_done
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             accept;
    logic             par_bit;
    logic             par_en_q;
    logic             par_bit_q;

    parity_calc #(.DATA_W(DATA_W)) u_parity (
        .P_DATA  (P_DATA),
        .PAR_TYP (PAR_TYP),
        .par_bit (par_bit)
    );

    assign last   = cnt == CNT_W'(DATA_W - 1);
    assign accept = (state == IDLE) && Data_Valid;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // bit counter: held at zero outside DATA, counts 0..DATA_W-1 inside it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              cnt <= '0;
        else if (state != DATA)  cnt <= '0;
        else if (!last)          cnt <= cnt + CNT_W'(1);
    end

    // frame configuration captured at acceptance so mid-frame input changes are harmless
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else if (accept) begin
            par_en_q  <= PAR_EN;
            par_bit_q <= par_bit;
        end
    end

    // next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = Data_Valid ? START : IDLE;
            START:   state_nxt = DATA;
            DATA:    state_nxt = last ? (par_en_q ? PARITY : STOP) : DATA;
            PARITY:  state_nxt = STOP;
            STOP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // outputs decoded from registered state only
    always_comb begin
        busy       = state != IDLE;
        frame_done = state == STOP;
        ser_en     = (state == START) || ((state == DATA) && !last);
        TX_OUT     = (state == START)  ? 1'b0 :
                     (state == DATA)   ? ser_data :
                     (state == PARITY) ? par_bit_q : 1'b1;
    end

endmodule
